byte_checksum_accum: RTL and testbench
======================================

BYTE_CHECKSUM_ACCUM -- requirements
Module: byte_checksum_accum

Interface
REQ-001 Parameter: CARRY_W, 8, width of the saturating carry-count output.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream byte present.
REQ-005 Port: in_ready  output  1  block can accept a byte this cycle.
REQ-006 Port: in_data  input  8  message byte.
REQ-007 Port: in_last  input  1  qualifies in_data as the final byte of the message.
REQ-008 Port: out_valid  output  1  message result available.
REQ-009 Port: out_ready  input  1  downstream takes the result.
REQ-010 Port: out_sum  output  8  sum of all message bytes, mod 256.
REQ-011 Port: out_carries  output  CARRY_W  count of carry-outs from the byte additions, saturating.
REQ-012 Port: out_len  output  8  accepted byte count, saturating at 255.
REQ-013 Port: out_len_ovf  output  1  set when the message exceeded 255 bytes.

Function
REQ-014 States SHALL be IDLE, ACCUM and DONE; the reset state is IDLE.
REQ-015 Accept SHALL mean in_valid and in_ready both high on a rising edge.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE and while rst is high.
REQ-017 On accept: sum <= sum + in_data (8-bit, carry-out c); carries <= carries + c, saturating at 2^CARRY_W-1; len <= len + 1, saturating at 255.
REQ-018 On an accept that increments len from 255, out_len_ovf SHALL be set and held until the message is consumed.
REQ-019 Transitions: IDLE or ACCUM, accept with in_last=0 -> ACCUM; IDLE or ACCUM, accept with in_last=1 -> DONE; DONE with out_ready=1 -> IDLE; all other cases hold the current state.
REQ-020 out_valid SHALL equal (state==DONE), asserting on the cycle after the last byte is accepted, so latency is 1 cycle.
REQ-021 In DONE, out_sum, out_carries, out_len and out_len_ovf SHALL remain stable until the handshake, whatever the value of in_valid.
REQ-022 On the DONE-to-IDLE handshake, sum, carries, len and out_len_ovf SHALL clear to 0 on the same edge.
REQ-023 Outputs SHALL be driven directly from registers at all times; they are meaningful only while out_valid=1.
REQ-024 Throughput SHALL be one byte per cycle within a message, with a minimum of one bubble cycle (DONE) between messages.
REQ-025 A byte in IDLE with in_last=1 SHALL form a complete 1-byte message.

Reset
REQ-026 When rst is asserted, the block SHALL go to IDLE immediately, with all accumulators, out_valid and out_len_ovf at 0, independent of clk.
REQ-027 Reset mid-message SHALL discard the partial message; the first accept after reset starts a new message.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, ACCUM, DONE) and the length-width constant (8).
REQ-029 The byte addition SHALL instantiate the team's eight_bit_adder as the single sub-module, with carry-in 0.
REQ-030 The carry and length saturation logic SHALL be local to byte_checksum_accum.

Verification
REQ-031 Input 0x10, 0x20, 0x30 (last) -> out_valid one cycle later with sum 0x60, carries 0, len 3, ovf 0.
REQ-032 Input 0xFF, 0x01, 0xFF, 0x02 (last) -> sum 0x01, carries 2, len 4.
REQ-033 Single byte 0xA5 with last, sent from IDLE -> sum 0xA5, carries 0, len 1, no transition through ACCUM.
REQ-034 out_ready held 0 for 5 cycles in DONE while in_valid=1 -> out_valid stays 1, in_ready stays 0, outputs stable, no byte accepted; on out_ready=1 the next cycle is IDLE with accumulators at 0.
REQ-035 300 bytes of 0xFF, the last one flagged -> sum 0xD4, carries 255 (saturated), len 255, ovf 1.
REQ-036 rst pulsed after 2 bytes of a message, then 0x05 (last) -> sum 0x05, len 1, carries 0.

Source files
------------

// File: rtl/byte_checksum_accum_pkg.sv
// Shared types and constants for the byte checksum accumulator.
// Holds the message FSM state encoding and the byte/length width.
package byte_checksum_accum_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/eight_bit_adder.sv
// Team 8-bit ripple adder with carry-in and carry-out.
module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign sum   = total[7:0];
    assign cout  = total[8];

endmodule

// File: rtl/byte_checksum_accum.sv
// Accumulates a byte stream into a mod-256 sum, a saturating carry count and a
// saturating length, presenting the result for one handshake per message.
module byte_checksum_accum
    import byte_checksum_accum_pkg::*;
#(
    parameter int CARRY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LEN_W-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEN_W-1:0]   out_sum,
    output logic [CARRY_W-1:0] out_carries,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_len_ovf
);

    localparam logic [CARRY_W-1:0] CARRY_MAX = '1;
    localparam logic [LEN_W-1:0]   LEN_MAX   = '1;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   sum_q;
    logic [LEN_W-1:0]   len_q;
    logic [CARRY_W-1:0] carries_q;
    logic               ovf_q;
    logic [LEN_W-1:0]   add_sum;
    logic               add_cout;
    logic               accept;
    logic               consume;

    eight_bit_adder u_adder (
        .a    (sum_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Reset gates in_ready combinationally so no byte is taken while rst is high.
    assign in_ready = !rst && (state != DONE);
    assign accept   = in_valid && in_ready;
    assign consume  = (state == DONE) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulators clear on the consuming handshake; DONE never accepts, so results hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            len_q     <= '0;
            carries_q <= '0;
            ovf_q     <= 1'b0;
        end else if (consume) begin
            sum_q     <= '0;
            len_q     <= '0;
            carries_q <= '0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            sum_q <= add_sum;
            if (add_cout && (carries_q != CARRY_MAX)) begin
                carries_q <= carries_q + CARRY_W'(1);
            end
            if (len_q != LEN_MAX) begin
                len_q <= len_q + LEN_W'(1);
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_valid   = (state == DONE);
    assign out_sum     = sum_q;
    assign out_carries = carries_q;
    assign out_len     = len_q;
    assign out_len_ovf = ovf_q;

endmodule

// File: tb/tb_byte_checksum_accum.sv
// Self-checking bench for byte_checksum_accum: an arithmetic message model
// checked every cycle, plus hand-computed literal results per directed message.
module tb_byte_checksum_accum;

    localparam int CARRY_W   = 8;
    localparam int CARRY_MAX = (1 << CARRY_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_data = 8'd0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [7:0]         out_sum;
    logic [CARRY_W-1:0] out_carries;
    logic [7:0]         out_len;
    logic               out_len_ovf;

    int passCount = 0;
    int checkCount = 0;

    // Model state: the message is summarised by its byte total and byte count.
    bit expDone = 1'b0;
    int expTotal = 0;
    int expCount = 0;

    byte_checksum_accum #(.CARRY_W(CARRY_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .out_len     (out_len),
        .out_len_ovf (out_len_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Repeated mod-256 addition carries out exactly floor(total/256) times.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expDone  = 1'b0;
            expTotal = 0;
            expCount = 0;
        end else if (expDone) begin
            if (out_ready) begin
                expDone  = 1'b0;
                expTotal = 0;
                expCount = 0;
            end
        end else if (in_valid) begin
            expTotal += int'(in_data);
            expCount++;
            if (in_last) expDone = 1'b1;
        end
    end

    always @(posedge clk) begin
        #2;
        check("in_ready", int'(in_ready), int'(!rst && !expDone));
        check("out_valid", int'(out_valid), int'(expDone));
        if (expDone || expCount == 0) begin
            check("model_sum", int'(out_sum), expTotal % 256);
            check("model_carries", int'(out_carries),
                  (expTotal / 256 > CARRY_MAX) ? CARRY_MAX : expTotal / 256);
            check("model_len", int'(out_len), (expCount > 255) ? 255 : expCount);
            check("model_ovf", int'(out_len_ovf), int'(expCount > 255));
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(negedge clk);
    endtask

    task automatic endMessage();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int sum, input int carries,
                               input int len, input int ovf);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_sum"}, int'(out_sum), sum);
        check({name, "_carries"}, int'(out_carries), carries);
        check({name, "_len"}, int'(out_len), len);
        check({name, "_ovf"}, int'(out_len_ovf), ovf);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h30, 1'b1);
        endMessage();
        checkOutput("msg3b", 'h60, 0, 3, 0);
        handshake();

        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h02, 1'b1);
        endMessage();
        checkOutput("msgcarry", 'h01, 2, 4, 0);
        handshake();

        applyStimulus(8'hA5, 1'b1);
        endMessage();
        checkOutput("single", 'hA5, 0, 1, 0);
        handshake();

        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h90, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold", 'h10, 1, 2, 0);
            check("hold_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        endMessage();
        handshake();
        check("cleared_valid", int'(out_valid), 0);
        check("cleared_sum", int'(out_sum), 0);
        check("cleared_len", int'(out_len), 0);
        check("cleared_carries", int'(out_carries), 0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'hFF, (i == 299));
        end
        endMessage();
        checkOutput("long", 'hD4, 255, 255, 1);
        handshake();

        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        endMessage();
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(in_ready), 0);
        check("midrst_len", int'(out_len), 0);
        check("midrst_sum", int'(out_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(8'h05, 1'b1);
        endMessage();
        checkOutput("afterrst", 'h05, 0, 1, 0);
        handshake();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
